// File: rtl/sram_responder_if.sv
// Request/response bus between an initiator and the single-port SRAM responder.
// One request may be outstanding; both channels use valid/ready handshakes.
interface sram_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/sram_responder.sv
// Byte-maskable 32-bit SRAM target with a fixed, parameterised response latency.
// Storage is split into four byte-lane RAMs so each lane infers a plain block RAM.
module sram_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic clk,
   input  logic rst,
   sram_responder_if.slave bus_if
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic             rsp_rd_sel_q;
   logic             pend_err_q;
   logic             pend_rd_q;

   logic [31:0]      offset;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic [31:0]      rd_word;

   // Range check is widened to 33 bits so addresses near 2^32 cannot wrap into range.
   assign offset   = bus_if.req_addr - BASE_ADDR;
   assign in_range = ({1'b0, bus_if.req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, offset} < SPAN);
   assign idx      = offset[IDX_W+1:2];
   assign accept   = bus_if.req_valid && req_ready_q && !rst;

   // Writes commit and reads sample at the acceptance edge; the read register then
   // holds still until the next acceptance, which cannot happen before the response ends.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
         if (accept && in_range) begin
            if (bus_if.req_wen) begin
               if (bus_if.req_wmask[gi]) begin
                  lane_mem[idx] <= bus_if.req_wdata[8*gi +: 8];
               end
            end else begin
               lane_rd_q <= lane_mem[idx];
            end
         end
      end

      assign rd_word[8*gi +: 8] = lane_rd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rd_sel_q <= 1'b0;
         pend_err_q   <= 1'b0;
         pend_rd_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus_if.req_valid) begin
                  req_ready_q <= 1'b0;
                  pend_err_q  <= !in_range;
                  pend_rd_q   <= in_range && !bus_if.req_wen;
                  if (LATENCY == 1) begin
                     state_q      <= RESP;
                     rsp_valid_q  <= 1'b1;
                     rsp_err_q    <= !in_range;
                     rsp_rd_sel_q <= in_range && !bus_if.req_wen;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q      <= RESP;
                  rsp_valid_q  <= 1'b1;
                  rsp_err_q    <= pend_err_q;
                  rsp_rd_sel_q <= pend_rd_q;
               end
            end
            RESP: begin
               if (bus_if.rsp_ready) begin
                  state_q      <= IDLE;
                  req_ready_q  <= 1'b1;
                  rsp_valid_q  <= 1'b0;
                  rsp_err_q    <= 1'b0;
                  rsp_rd_sel_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus_if.req_ready = req_ready_q;
   assign bus_if.rsp_valid = rsp_valid_q;
   assign bus_if.rsp_err   = rsp_err_q;
   assign bus_if.rsp_rdata = rsp_rd_sel_q ? rd_word : 32'h0;

endmodule

// File: tb/tb_sram_responder.sv
// Randomised bench for sram_responder: a word-array model predicts every response,
// and a second instance with LATENCY=1 covers back-to-back streaming.
module tb_sram_responder;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam int          LAT_A = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_responder_if bus_a ();
   sram_responder_if bus_b ();

   sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_a)
   );

   sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_b)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_mem [int];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_in_range(input logic [31:0] a);
      longint unsigned ua = longint'(a);
      longint unsigned lo = longint'(BASE);
      return (ua >= lo) && (ua < lo + 64'(4 * DEPTH));
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   // Drive one request on bus_a and check the whole response life cycle.
   task automatic txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask, input int hold,
                      input logic [31:0] exp_rdata, input bit exp_err);
      int lat;
      @(negedge clk);
      check_eq("ready_idle", 32'(bus_a.req_ready), 32'd1);
      bus_a.req_valid = 1'b1;
      bus_a.req_wen   = wen;
      bus_a.req_addr  = addr;
      bus_a.req_wdata = wdata;
      bus_a.req_wmask = wmask;
      bus_a.rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      // A stray write to word 0 stays asserted while busy; it must be ignored.
      bus_a.req_wen   = 1'b1;
      bus_a.req_addr  = BASE;
      bus_a.req_wdata = 32'hBAD0_BAD0;
      bus_a.req_wmask = 4'hF;
      bus_a.rsp_ready = 1'b1;
      lat = 1;
      while (bus_a.rsp_valid !== 1'b1 && lat < 40) begin
         check_eq("wait_rdata_zero", bus_a.rsp_rdata, 32'h0);
         check_eq("wait_err_zero", 32'(bus_a.rsp_err), 32'd0);
         check_eq("wait_ready_low", 32'(bus_a.req_ready), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq("latency", 32'(lat), 32'(LAT_A));
      bus_a.rsp_ready = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) begin
            @(posedge clk);
            #1;
         end
         check_eq("rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
         check_eq("rsp_rdata", bus_a.rsp_rdata, exp_rdata);
         check_eq("rsp_err", 32'(bus_a.rsp_err), 32'(exp_err));
         check_eq("resp_ready_low", 32'(bus_a.req_ready), 32'd0);
      end
      bus_a.req_valid = 1'b0;
      bus_a.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_a.rsp_ready = 1'b0;
      check_eq("post_valid_low", 32'(bus_a.rsp_valid), 32'd0);
      check_eq("post_rdata_zero", bus_a.rsp_rdata, 32'h0);
      check_eq("post_err_zero", 32'(bus_a.rsp_err), 32'd0);
      check_eq("post_ready_high", 32'(bus_a.req_ready), 32'd1);
      $display("txn %s addr=%h wdata=%h mask=%h exp_rdata=%h exp_err=%0d lat=%0d hold=%0d",
               wen ? "WR" : "RD", addr, wdata, wmask, exp_rdata, exp_err, lat, hold);
   endtask

   // Predict the response from the model, update it, then run the transaction.
   task automatic op(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wmask, input int hold);
      logic [31:0] exp_rdata = 32'h0;
      bit          exp_err   = !model_in_range(addr);
      int          i;
      if (!exp_err) begin
         i = model_idx(addr);
         if (!wen) begin
            exp_rdata = model_mem.exists(i) ? model_mem[i] : 32'h0;
         end else begin
            logic [31:0] w = model_mem.exists(i) ? model_mem[i] : 32'h0;
            for (int b = 0; b < 4; b++) begin
               if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
            end
            model_mem[i] = w;
         end
      end
      txn(wen, addr, wdata, wmask, hold, exp_rdata, exp_err);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b_word;
      int          pick;

      rst = 1'b1;
      bus_a.req_valid = 1'b0; bus_a.req_wen = 1'b0; bus_a.req_addr = '0;
      bus_a.req_wdata = '0;   bus_a.req_wmask = '0; bus_a.rsp_ready = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.req_wen = 1'b0; bus_b.req_addr = '0;
      bus_b.req_wdata = '0;   bus_b.req_wmask = '0; bus_b.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_ready", 32'(bus_a.req_ready), 32'd1);
      check_eq("rst_valid", 32'(bus_a.rsp_valid), 32'd0);
      check_eq("rst_rdata", bus_a.rsp_rdata, 32'h0);
      check_eq("rst_err", 32'(bus_a.rsp_err), 32'd0);
      check_eq("rst_b_ready", 32'(bus_b.req_ready), 32'd1);
      check_eq("rst_b_valid", 32'(bus_b.rsp_valid), 32'd0);

      for (int i = 0; i < 16; i++) op(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0);
      op(1'b1, BASE + 32'hFFC, $urandom, 4'hF, 0);

      // Directed cases: full write/read, partial mask, out-of-range, boundary, long hold.
      op(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
      op(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0);
      op(1'b1, BASE + 32'h10, 32'h00AA_0055, 4'b0101, 1);
      op(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0);
      op(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0);
      op(1'b0, 32'h8000_1000, 32'h0, 4'h0, 0);
      op(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0);
      op(1'b1, 32'h8000_1000, 32'h1111_2222, 4'hF, 0);
      op(1'b1, BASE + 32'h14, 32'h5555_AAAA, 4'h0, 0);
      op(1'b0, BASE + 32'h14, 32'h0, 4'h0, 0);
      op(1'b0, BASE + 32'h0, 32'h0, 4'h0, 0);
      op(1'b0, BASE + 32'hFFE, 32'h0, 4'h0, 0);
      op(1'b0, BASE + 32'h10, 32'h0, 4'h0, 5);

      // Reset one cycle after a write is accepted: no response, but the write sticks.
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b1; bus_a.req_addr = BASE + 32'h20;
      bus_a.req_wdata = 32'h1234_5678; bus_a.req_wmask = 4'hF; bus_a.rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      bus_a.req_valid = 1'b0;
      rst = 1'b1;
      model_mem[8] = 32'h1234_5678;
      @(posedge clk);
      #1;
      check_eq("abort_valid_in_rst", 32'(bus_a.rsp_valid), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check_eq("abort_valid_after", 32'(bus_a.rsp_valid), 32'd0);
         check_eq("abort_ready_after", 32'(bus_a.req_ready), 32'd1);
      end
      $display("txn RST-ABORT addr=%h wdata=%h", BASE + 32'h20, 32'h1234_5678);
      op(1'b0, BASE + 32'h20, 32'h0, 4'h0, 0);

      for (int n = 0; n < 80; n++) begin
         pick = int'($urandom_range(0, 9));
         case (pick)
            0:       a = $urandom_range(0, 32'h7FFF_FFFF);
            1:       a = BASE + 32'h1000 + $urandom_range(0, 4095);
            2:       a = 32'hFFFF_FFFC;
            3:       a = BASE + 32'hFFC + $urandom_range(0, 3);
            default: a = BASE + 32'(4 * $urandom_range(0, 15)) + $urandom_range(0, 3);
         endcase
         op($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)));
      end

      // LATENCY=1 instance: one write, then a stream of reads with rsp_ready held high.
      b_word = $urandom;
      @(negedge clk);
      bus_b.req_valid = 1'b1; bus_b.req_wen = 1'b1; bus_b.req_addr = BASE + 32'h40;
      bus_b.req_wdata = b_word; bus_b.req_wmask = 4'hF; bus_b.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_b.req_valid = 1'b0;
      check_eq("b_wr_valid", 32'(bus_b.rsp_valid), 32'd1);
      check_eq("b_wr_rdata", bus_b.rsp_rdata, 32'h0);
      @(posedge clk);
      #1;
      check_eq("b_wr_done", 32'(bus_b.rsp_valid), 32'd0);
      $display("txn B-WR addr=%h wdata=%h", BASE + 32'h40, b_word);
      bus_b.req_wen   = 1'b0;
      bus_b.req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         check_eq("b_stream_valid", 32'(bus_b.rsp_valid), 32'(k % 2 == 0));
         check_eq("b_stream_rdata", bus_b.rsp_rdata, (k % 2 == 0) ? b_word : 32'h0);
         check_eq("b_stream_ready", 32'(bus_b.req_ready), 32'(k % 2 != 0));
         if (k % 2 == 0) $display("txn B-RD addr=%h exp_rdata=%h", BASE + 32'h40, b_word);
      end
      bus_b.req_valid = 1'b0;
      bus_b.rsp_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
